// File: rtl/adder_multicycle_pkg.sv
// rtl/adder_multicycle_pkg.sv - shared state encodings, mode constants and sizing helper
package adder_multicycle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_full.sv
// rtl/adder_full.sv - one-bit full adder cell
module adder_full (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/adder_multicycle_chunk.sv
// rtl/adder_multicycle_chunk.sv - combinational CHUNK-bit ripple adder built from adder_full cells
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] out,
    output logic             carry_out,
    output logic             msb_carry_in
);

    logic [CHUNK:0] carry;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        adder_full u_fa (
            .a         (a[i]),
            .b         (b[i]),
            .carry_in  (carry[i]),
            .sum       (out[i]),
            .carry_out (carry[i+1])
        );
    end

    // The carry entering the top bit is needed by the caller for signed overflow.
    assign carry_out    = carry[CHUNK];
    assign msb_carry_in = carry[CHUNK-1];

endmodule

// File: rtl/adder_multicycle.sv
// rtl/adder_multicycle.sv - add/subtract WIDTH-bit operands one CHUNK per cycle with start/busy/done
module adder_multicycle
    import adder_multicycle_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = idx_width(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  out_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic              busy_q;
    logic              done_q;
    logic              cout_q;
    logic              ovf_q;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  sum_chunk;
    logic              chunk_cout;
    logic              chunk_msb_cin;
    logic              last_chunk;
    logic [WIDTH-1:0]  b_eff;

    // Select the operand slice for the current chunk index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    assign last_chunk = (idx_q == LAST_IDX);
    assign b_eff      = (sub == MODE_SUB) ? ~b : b;

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a            (a_chunk),
        .b            (b_chunk),
        .carry_in     (carry_q),
        .out          (sum_chunk),
        .carry_out    (chunk_cout),
        .msb_carry_in (chunk_msb_cin)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= (sub == MODE_SUB) ? 1'b1 : carry_in;
                        idx_q   <= '0;
                        out_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < N; k++) begin
                        if (idx_q == IDXW'(k)) begin
                            out_q[k*CHUNK +: CHUNK] <= sum_chunk;
                        end
                    end
                    carry_q <= chunk_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (last_chunk) begin
                        cout_q  <= chunk_cout;
                        ovf_q   <= chunk_msb_cin ^ chunk_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out       = out_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_multicycle.sv
// tb/tb_adder_multicycle.sv - scoreboard bench for adder_multicycle at CHUNK 8, 32 and 1
module tb_adder_multicycle;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] out;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sub = 1'b0;
    logic        carry_in = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        start_v [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        cout_v  [3];
    logic        ovf_v   [3];
    logic [31:0] out_v   [3];

    res_t sb[$];
    res_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    adder_multicycle #(.WIDTH(32), .CHUNK(8)) u_c8 (
        .clk(clk), .reset(reset), .start(start_v[0]), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy_v[0]), .done(done_v[0]), .out(out_v[0]),
        .carry_out(cout_v[0]), .overflow(ovf_v[0])
    );

    adder_multicycle #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .clk(clk), .reset(reset), .start(start_v[1]), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy_v[1]), .done(done_v[1]), .out(out_v[1]),
        .carry_out(cout_v[1]), .overflow(ovf_v[1])
    );

    adder_multicycle #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .clk(clk), .reset(reset), .start(start_v[2]), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy_v[2]), .done(done_v[2]), .out(out_v[2]),
        .carry_out(cout_v[2]), .overflow(ovf_v[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [1:0] sel, input logic [31:0] ta, input logic [31:0] tb_,
                                   input logic ts, input logic tc);
        res_t        r;
        logic [31:0] beff;
        logic [32:0] s;
        beff   = ts ? ~tb_ : tb_;
        s      = {1'b0, ta} + {1'b0, beff} + {32'd0, (ts ? 1'b1 : tc)};
        r.sel  = sel;
        r.out  = s[31:0];
        r.cout = s[32];
        r.ovf  = (ta[31] == beff[31]) && (s[31] != ta[31]);
        return r;
    endfunction

    // Called at posedge+1; start is seen by the DUT on the following edge.
    task automatic launch(input int sel, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic ts, input logic tc);
        a = ta;
        b = tb_;
        sub = ts;
        carry_in = tc;
        start_v[sel] = 1'b1;
        sb.push_back(model(2'(sel), ta, tb_, ts, tc));
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int exp_lat, input int elapsed, input string tag);
        int cyc;
        cyc = elapsed;
        while (done_v[sel] !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    check($sformatf("unexpected_done%0d", i), {63'd0, done_v[i]}, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check($sformatf("sb_sel%0d", i), 64'(i), 64'(mon_e.sel));
                    check($sformatf("sb_out%0d", i), 64'(out_v[i]), 64'(mon_e.out));
                    check($sformatf("sb_cout%0d", i), 64'(cout_v[i]), 64'(mon_e.cout));
                    check($sformatf("sb_ovf%0d", i), 64'(ovf_v[i]), 64'(mon_e.ovf));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_v[0]), 64'd0);
        check("rst_done", 64'(done_v[0]), 64'd0);
        check("rst_out", 64'(out_v[0]), 64'd0);
        check("rst_cout", 64'(cout_v[0]), 64'd0);
        check("rst_ovf", 64'(ovf_v[0]), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        launch(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        check("busy_after_start", 64'(busy_v[0]), 64'd1);
        wait_done(0, 4, 0, "wrap");
        check("wrap_out", 64'(out_v[0]), 64'h0);
        check("wrap_cout", 64'(cout_v[0]), 64'd1);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done_v[0]), 64'd0);

        launch(0, 32'd5, 32'd7, 1'b1, 1'b0);
        wait_done(0, 4, 0, "sub5_7");
        check("sub5_7_out", 64'(out_v[0]), 64'hFFFF_FFFE);
        check("sub5_7_cout", 64'(cout_v[0]), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_out", 64'(out_v[0]), 64'hFFFF_FFFE);

        launch(0, 32'd7, 32'd5, 1'b1, 1'b1);
        wait_done(0, 4, 0, "sub7_5");
        check("sub7_5_out", 64'(out_v[0]), 64'h2);
        check("sub7_5_cout", 64'(cout_v[0]), 64'd1);

        // Back-to-back starts: the second is raised during the done cycle.
        launch(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        wait_done(0, 4, 0, "ovf_add");
        check("ovf_add_out", 64'(out_v[0]), 64'h8000_0000);
        check("ovf_add_flag", 64'(ovf_v[0]), 64'd1);
        launch(0, 32'h8000_0000, 32'h1, 1'b1, 1'b0);
        check("b2b_busy", 64'(busy_v[0]), 64'd1);
        wait_done(0, 4, 0, "ovf_sub");
        check("ovf_sub_out", 64'(out_v[0]), 64'h7FFF_FFFF);
        check("ovf_sub_flag", 64'(ovf_v[0]), 64'd1);
        @(posedge clk);
        #1;

        launch(0, 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        a = 32'hDEAD_BEEF;
        b = 32'h0BAD_F00D;
        sub = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done(0, 4, 2, "ignored_start");
        check("ignored_out", 64'(out_v[0]), 64'h1234_5678);
        repeat (6) @(posedge clk);
        #1;

        // Reset lands on the second RUN cycle; the pending result is dropped.
        launch(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        check("midrst_busy", 64'(busy_v[0]), 64'd0);
        check("midrst_done", 64'(done_v[0]), 64'd0);
        check("midrst_out", 64'(out_v[0]), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        launch(0, 32'd3, 32'd4, 1'b0, 1'b0);
        wait_done(0, 4, 0, "after_rst");
        check("after_rst_out", 64'(out_v[0]), 64'd7);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            launch(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done(0, 4, 0, "rand8");
            @(posedge clk);
            #1;
        end

        launch(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        wait_done(1, 1, 0, "c32");
        check("c32_out", 64'(out_v[1]), 64'h2345_678A);
        @(posedge clk);
        #1;

        launch(2, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        wait_done(2, 32, 0, "c1");
        check("c1_out", 64'(out_v[2]), 64'h2345_678A);
        @(posedge clk);
        #1;
        launch(2, 32'h8000_0000, 32'h1, 1'b1, 1'b0);
        wait_done(2, 32, 0, "c1_sub");

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
